uart_image_streamer: RTL

Synthesizable stimulus engine that streams byte-serialised digit images from a ROM into the SNN through a uart_tx instance, then captures each one-byte classification returned through a uart_rx instance.
It generalises the single-image, fixed-98-byte send/receive loop to N images of configurable length, configurable ROM latency, and an optional response watchdog.
It sits beside SNN in system-level benches and in on-board self-test builds.

---
 rtl/snn_stream_pkg.sv | 20 ++
 rtl/stream_addr_gen.sv | 64 ++++++
 rtl/uart_image_streamer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/snn_stream_pkg.sv
// ----------------------------------------------------------------------------
// snn_stream_pkg
// Shared types and constants for the UART image streamer.
//   streamer_state_t : FSM state encoding of uart_image_streamer
//   TIMEOUT_BYTE     : result byte recorded when the response watchdog fires
// ----------------------------------------------------------------------------
package snn_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_RX,
        ST_DONE
    } streamer_state_t;

    localparam logic [7:0] TIMEOUT_BYTE = 8'hFF;

endpackage

// File: rtl/stream_addr_gen.sv
// ----------------------------------------------------------------------------
// stream_addr_gen
// Byte and image counters plus the ROM address, which is kept equal to
// img_cnt*BYTES_PER_IMAGE + byte_cnt by incrementing instead of multiplying.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : zero both counters and the address (run start)
//   byte_adv     : next byte of the same image (byte_cnt++, rom_addr++)
//   image_end    : last byte of the image sent (byte_cnt -> 0)
//   image_adv    : next image (img_cnt++, rom_addr++)
//   rom_addr     : current ROM address
//   img_cnt      : current image index
//   last_byte    : byte_cnt == BYTES_PER_IMAGE-1
//   last_image   : img_cnt  == NUM_IMAGES-1
// ----------------------------------------------------------------------------
module stream_addr_gen #(
    parameter int unsigned BYTES_PER_IMAGE = 98,
    parameter int unsigned NUM_IMAGES      = 4,
    parameter int unsigned ADDR_WIDTH      = 9,
    parameter int unsigned IDX_WIDTH       = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_adv,
    input  logic                  image_end,
    input  logic                  image_adv,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [IDX_WIDTH-1:0]  img_cnt,
    output logic                  last_byte,
    output logic                  last_image
);

    localparam int unsigned BCW = $clog2(BYTES_PER_IMAGE + 1);

    logic [BCW-1:0] byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            img_cnt  <= '0;
            rom_addr <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            img_cnt  <= '0;
            rom_addr <= '0;
        end else begin
            if (byte_adv) begin
                byte_cnt <= byte_cnt + BCW'(1);
                rom_addr <= rom_addr + ADDR_WIDTH'(1);
            end else if (image_end) begin
                // address stays on the last byte; image_adv steps it into the next image
                byte_cnt <= '0;
            end else if (image_adv) begin
                img_cnt  <= img_cnt + IDX_WIDTH'(1);
                rom_addr <= rom_addr + ADDR_WIDTH'(1);
            end
        end
    end

    assign last_byte  = (byte_cnt == BCW'(BYTES_PER_IMAGE - 1));
    assign last_image = (img_cnt == IDX_WIDTH'(NUM_IMAGES - 1));

endmodule

// File: rtl/uart_image_streamer.sv
// ----------------------------------------------------------------------------
// uart_image_streamer
// Streams NUM_IMAGES images of BYTES_PER_IMAGE bytes from a ROM to a uart_tx,
// and captures one classification byte per image from a uart_rx.
// Optional build macro: STREAMER_TIMEOUT_EN enables a response watchdog in
// WAIT_RX; when undefined the block waits forever and timeout is tied 0.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle pulse, starts a run when idle
//   rom_addr / rom_data   : ROM read port (data valid ROM_LATENCY cycles later)
//   tx_start / tx_data    : one-cycle send strobe and byte to uart_tx
//   tx_rdy                : uart_tx idle flag (rising edge = byte finished)
//   rx_rdy / rx_data      : uart_rx byte-received pulse and byte
//   busy                  : run in progress
//   result_valid          : one-cycle pulse per captured result
//   result_data/idx       : captured byte and its image index
//   done                  : high from end of run until next start
//   timeout               : sticky watchdog error, cleared by start
// ----------------------------------------------------------------------------
module uart_image_streamer
    import snn_stream_pkg::*;
#(
    parameter int unsigned BYTES_PER_IMAGE = 98,
    parameter int unsigned NUM_IMAGES      = 4,
    parameter int unsigned ADDR_WIDTH      = 9,
    parameter int unsigned ROM_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 2000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [7:0]                    rom_data,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    input  logic                          tx_rdy,
    input  logic                          rx_rdy,
    input  logic [7:0]                    rx_data,
    output logic                          busy,
    output logic                          result_valid,
    output logic [7:0]                    result_data,
    output logic [$clog2(NUM_IMAGES):0]   result_idx,
    output logic                          done,
    output logic                          timeout
);

    localparam int unsigned IDX_WIDTH = $clog2(NUM_IMAGES) + 1;

    streamer_state_t state, state_next;

    logic                 clear, byte_adv, image_end, image_adv;
    logic                 latch_tx, capture;
    logic                 last_byte, last_image;
    logic [IDX_WIDTH-1:0] img_cnt;
    logic [2:0]           lat_cnt;
    logic                 tx_rdy_q;
    logic                 tx_rdy_rise;
    logic                 timeout_hit;

    stream_addr_gen #(
        .BYTES_PER_IMAGE (BYTES_PER_IMAGE),
        .NUM_IMAGES      (NUM_IMAGES),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .IDX_WIDTH       (IDX_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .byte_adv   (byte_adv),
        .image_end  (image_end),
        .image_adv  (image_adv),
        .rom_addr   (rom_addr),
        .img_cnt    (img_cnt),
        .last_byte  (last_byte),
        .last_image (last_image)
    );

    // A tx_rdy that is already high on entry is not a completion; only 0->1 counts.
    assign tx_rdy_rise = tx_rdy && !tx_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        byte_adv   = 1'b0;
        image_end  = 1'b0;
        image_adv  = 1'b0;
        latch_tx   = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (lat_cnt == 3'(ROM_LATENCY)) begin
                    latch_tx   = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_rdy_rise) begin
                    if (!last_byte) begin
                        byte_adv   = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        image_end  = 1'b1;
                        state_next = ST_WAIT_RX;
                    end
                end
            end
            ST_WAIT_RX: begin
                if (rx_rdy || timeout_hit) begin
                    capture = 1'b1;
                    if (!last_image) begin
                        image_adv  = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign tx_start = (state == ST_SEND);
    assign busy     = (state inside {ST_FETCH, ST_SEND, ST_WAIT_TX, ST_WAIT_RX});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt      <= '0;
            tx_rdy_q     <= 1'b0;
            tx_data      <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_idx   <= '0;
            done         <= 1'b0;
        end else begin
            tx_rdy_q     <= tx_rdy;
            lat_cnt      <= (state == ST_FETCH) ? lat_cnt + 3'd1 : '0;
            result_valid <= capture;
            if (latch_tx) begin
                tx_data <= rom_data;
            end
            if (capture) begin
                result_data <= timeout_hit ? TIMEOUT_BYTE : rx_data;
                result_idx  <= img_cnt;
            end
            if (clear) begin
                done <= 1'b0;
            end else if (capture && last_image) begin
                done <= 1'b1;
            end
        end
    end

`ifdef STREAMER_TIMEOUT_EN
    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_WIDTH-1:0] wd_cnt;

    // wd_cnt is 0 on the first WAIT_RX cycle, so the hit lands on cycle TIMEOUT_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state != ST_WAIT_RX) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_WIDTH'(1);
        end
    end

    assign timeout_hit = (state == ST_WAIT_RX) && !rx_rdy &&
                         (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (clear) begin
            timeout <= 1'b0;
        end else if (timeout_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
    assign timeout            = 1'b0;
`endif

endmodule
